int_ctrl: RTL and testbench

Interrupt controller for the c16 CPU. It collects four interrupt sources: video vblank, a programmable timer, key presses and sound-buffer-empty. It latches them as pending bits, masks them, and selects the highest-priority one. It then drives the CPU's `int_trig` line through a request/acknowledge/return handshake. The CPU configures it through the memory-mapped peripheral write port (`w_param`/`w_val`), alongside the video and sound units.

---
 rtl/int_ctrl.sv | 135 +++++++++++++
 tb/tb_int_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller for the c16 CPU: captures vblank/timer/key/snd events as
// pending bits, arbitrates by fixed priority and runs the trig/ack/done handshake.
module int_ctrl #(
    parameter int TIMER_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_wen,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_val,
    input  logic        vblank,
    input  logic [3:0]  key,
    input  logic        snd_empty,
    input  logic        int_ack,
    input  logic        int_done,
    output logic        int_trig,
    output logic [1:0]  int_cause,
    output logic [3:0]  pending,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t                         state, state_nxt;
    logic [3:0]                     mask;
    logic [TIMER_W-1:0]             reload, cnt;
    logic                           tmr_en, tmr_run, tmr_evt;
    logic [SYNC_STAGES-1:0][3:0]    key_sync;
    logic [3:0]                     key_q;
    logic                           vb_q;
    logic [3:0]                     evt, clr, masked, ack_mask;
    logic [1:0]                     winner, cause_nxt;
    logic                           ack_clr;

    assign tmr_run  = tmr_en && (reload != '0);
    assign tmr_evt  = tmr_run && (cnt == '0);
    assign masked   = pending & mask;
    assign ack_mask = 4'b0001 << int_cause;

    // Key press is a 1->0 transition at the output of the synchronizer.
    assign evt = {snd_empty,
                  |(key_q & ~key_sync[SYNC_STAGES-1]),
                  tmr_evt,
                  vblank & ~vb_q};

    assign clr = ({4{cfg_wen && cfg_addr == 2'd2}} & cfg_val[3:0])
               | (ack_clr ? ack_mask : 4'b0000);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_sync <= '0;
            key_q    <= '0;
            vb_q     <= 1'b0;
        end else begin
            key_sync[0] <= key;
            for (int i = 1; i < SYNC_STAGES; i++) key_sync[i] <= key_sync[i-1];
            key_q <= key_sync[SYNC_STAGES-1];
            vb_q  <= vblank;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mask   <= '0;
            reload <= '0;
            tmr_en <= 1'b0;
        end else if (cfg_wen) begin
            case (cfg_addr)
                2'd0:    mask   <= cfg_val[3:0];
                2'd1:    reload <= cfg_val[TIMER_W-1:0];
                2'd3:    tmr_en <= cfg_val[0];
                default: ;
            endcase
        end
    end

    // Counts reload..0 then reloads, giving a period of reload+1 clocks.
    always_ff @(posedge clk) begin
        if (!resetn)
            cnt <= '0;
        else if (cfg_wen && cfg_addr == 2'd1)
            cnt <= cfg_val[TIMER_W-1:0];
        else if (tmr_run)
            cnt <= (cnt == '0) ? reload : cnt - TIMER_W'(1);
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!resetn) pending <= '0;
        else         pending <= (pending & ~clr) | evt;
    end

    always_comb begin
        winner = 2'd0;
        if      (masked[0]) winner = 2'd0;
        else if (masked[1]) winner = 2'd1;
        else if (masked[2]) winner = 2'd2;
        else if (masked[3]) winner = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            int_cause <= 2'd0;
        end else begin
            state     <= state_nxt;
            int_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = int_cause;
        ack_clr   = 1'b0;
        case (state)
            IDLE: if (|masked) begin
                cause_nxt = winner;
                state_nxt = REQ;
            end
            REQ: if (int_ack) begin
                ack_clr   = 1'b1;
                state_nxt = SVC;
            end else if (!masked[int_cause]) begin
                state_nxt = IDLE;
            end
            SVC: if (int_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign int_trig = (state == REQ);
    assign busy     = (state == SVC);

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed handshake scenarios followed by random traffic,
// every cycle checked against a behavioural model of the controller.
module tb_int_ctrl;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_wen = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_val = '0;
    logic        vblank = 1'b0;
    logic [3:0]  key = 4'hF;
    logic        snd_empty = 1'b0;
    logic        int_ack = 1'b0;
    logic        int_done = 1'b0;
    logic        int_trig;
    logic [1:0]  int_cause;
    logic [3:0]  pending;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int_ctrl #(.TIMER_W(16), .SYNC_STAGES(S)) dut (
        .clk(clk), .resetn(resetn), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr),
        .cfg_val(cfg_val), .vblank(vblank), .key(key), .snd_empty(snd_empty),
        .int_ack(int_ack), .int_done(int_done), .int_trig(int_trig),
        .int_cause(int_cause), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 requesting, 2 servicing
    logic [3:0] m_pend = '0, m_mask = '0;
    int         m_reload = 0, m_tcnt = 0, m_st = 0;
    bit         m_en = 0;
    logic [1:0] m_cause = '0;
    logic       m_vb = 1'b0;
    logic [3:0] kh [0:S];   // kh[i] = key value sampled i+1 edges ago

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [3:0] set, clr, act;
        int cur;
        if (!resetn) begin
            m_pend = '0; m_mask = '0; m_reload = 0; m_tcnt = 0; m_en = 0;
            m_st = 0; m_cause = '0; m_vb = 1'b0;
            for (int i = 0; i <= S; i++) kh[i] = '0;
            return;
        end
        set = '0;
        if (vblank && !m_vb) set[0] = 1'b1;
        cur = (m_reload == 0) ? 0 : m_reload - m_tcnt;
        if (m_en && m_reload != 0 && cur == 0) set[1] = 1'b1;
        if ((kh[S] & ~kh[S-1]) != 4'b0) set[2] = 1'b1;
        if (snd_empty) set[3] = 1'b1;
        clr = '0;
        if (cfg_wen && cfg_addr == 2'd2) clr = cfg_val[3:0];
        if (m_st == 1 && int_ack) clr[m_cause] = 1'b1;
        act = m_pend & m_mask;
        case (m_st)
            0: if (act != 0) begin
                for (int i = 3; i >= 0; i--) if (act[i]) m_cause = 2'(i);
                m_st = 1;
            end
            1: if (int_ack) m_st = 2; else if (!act[m_cause]) m_st = 0;
            default: if (int_done) m_st = 0;
        endcase
        m_pend = (m_pend & ~clr) | set;
        if (cfg_wen && cfg_addr == 2'd1) begin
            m_reload = int'(cfg_val); m_tcnt = 0;
        end else if (m_en && m_reload != 0) begin
            m_tcnt = (m_tcnt + 1) % (m_reload + 1);
        end
        if (cfg_wen && cfg_addr == 2'd0) m_mask = cfg_val[3:0];
        if (cfg_wen && cfg_addr == 2'd3) m_en = cfg_val[0];
        m_vb = vblank;
        for (int i = S; i > 0; i--) kh[i] = kh[i-1];
        kh[0] = key;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("trig", int_trig, 32'(m_st == 1));
        chk("busy", busy, 32'(m_st == 2));
        chk("cause", int_cause, m_cause);
        chk("pending", pending, m_pend);
        cfg_wen = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] v);
        cfg_wen = 1'b1; cfg_addr = a; cfg_val = v;
        tick();
    endtask

    task automatic wait_trig(input string tag);
        int n = 0;
        while (!int_trig && n < 30) begin tick(); n++; end
        chk(tag, int_trig, 1);
    endtask

    initial begin
        int t0, t1, nev, b;
        logic [1:0] exp_c [3];
        t0 = 0; t1 = 0; nev = 0;
        for (int i = 0; i <= S; i++) kh[i] = '0;

        // reset state
        resetn = 1'b0; tick(); tick();
        chk("rst_trig", int_trig, 0); chk("rst_pend", pending, 0);
        chk("rst_busy", busy, 0); chk("rst_cause", int_cause, 0);
        resetn = 1'b1; tick();

        // vblank edge through ack/done
        cfg(2'd0, 16'hF);
        vblank = 1'b1; tick();
        chk("vb_pend", pending, 4'b0001);
        tick();
        chk("vb_trig", int_trig, 1); chk("vb_cause", int_cause, 0);
        int_ack = 1'b1; tick();
        chk("vb_ack_trig", int_trig, 0); chk("vb_ack_busy", busy, 1);
        chk("vb_ack_pend", pending, 0);
        int_done = 1'b1; tick();
        vblank = 1'b0; tick();

        // timer period with reload=5
        cfg(2'd0, 16'h0); cfg(2'd2, 16'hF); cfg(2'd1, 16'd5); cfg(2'd3, 16'd1);
        for (int i = 0; i < 40 && nev < 2; i++) begin
            tick();
            if (pending[1]) begin
                if (nev == 0) t0 = cyc; else t1 = cyc;
                nev++;
                cfg(2'd2, 16'h2);
            end
        end
        chk("tmr_events", nev, 2);
        chk("tmr_period", t1 - t0, 6);
        cfg(2'd0, 16'h2);
        wait_trig("tmr_trig");
        chk("tmr_cause", int_cause, 1);
        int_ack = 1'b1; tick();
        int_done = 1'b1; tick();
        cfg(2'd1, 16'd0); cfg(2'd2, 16'hF);
        repeat (15) tick();
        chk("tmr_halt_pend", pending[1], 0);
        chk("tmr_halt_trig", int_trig, 0);

        // simultaneous vblank, key[2], snd -> serviced 0,2,3
        cfg(2'd3, 16'd0); cfg(2'd0, 16'hF);
        exp_c[0] = 2'd0; exp_c[1] = 2'd2; exp_c[2] = 2'd3;
        vblank = 1'b1; key = 4'b1011; snd_empty = 1'b1; tick();
        for (int r = 0; r < 3; r++) begin
            wait_trig("multi_trig");
            chk("multi_cause", int_cause, exp_c[r]);
            int_ack = 1'b1; tick();
            int_done = 1'b1; tick();
        end
        chk("snd_reset_pend", pending[3], 1);
        snd_empty = 1'b0; key = 4'hF; vblank = 1'b0;
        cfg(2'd0, 16'h0); cfg(2'd2, 16'hF); tick(); tick();

        // mask removed while requesting
        cfg(2'd0, 16'h1);
        vblank = 1'b1; tick(); tick();
        chk("rq_trig", int_trig, 1);
        cfg(2'd0, 16'h0); tick();
        chk("rq_drop_trig", int_trig, 0);
        chk("rq_keep_pend", pending[0], 1);

        // spurious ack in SVC, key queued, reissued 2 cycles after done
        cfg(2'd0, 16'hF); tick();
        chk("svc_req_cause", int_cause, 0);
        int_ack = 1'b1; tick();
        key = 4'b1011; int_ack = 1'b1; tick();
        repeat (4) tick();
        chk("svc_no_trig", int_trig, 0); chk("svc_busy", busy, 1);
        int_done = 1'b1; tick();
        chk("svc_done_trig", int_trig, 0);
        tick();
        chk("svc_next_trig", int_trig, 1); chk("svc_next_cause", int_cause, 2);

        // reset during SVC
        int_ack = 1'b1; tick();
        chk("rst_svc_busy_pre", busy, 1);
        resetn = 1'b0; tick();
        chk("rst_svc_busy", busy, 0); chk("rst_svc_pend", pending, 0);
        resetn = 1'b1; int_done = 1'b1; tick();
        chk("rst_done_busy", busy, 0); chk("rst_done_trig", int_trig, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom % 300) != 0;
            if ($urandom % 8 == 0) vblank = ~vblank;
            if ($urandom % 6 == 0) begin b = $urandom_range(3, 0); key[b] = ~key[b]; end
            snd_empty = ($urandom % 12) == 0;
            int_ack  = int_trig ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
            int_done = busy ? ($urandom % 4 == 0) : ($urandom % 25 == 0);
            if ($urandom % 8 == 0) begin
                cfg_wen  = 1'b1;
                cfg_addr = 2'($urandom);
                cfg_val  = (cfg_addr == 2'd1) ? 16'($urandom_range(7, 0)) : 16'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
